// File: rtl/mux_nx1_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_pkg
// Purpose  : Shared constants and helpers for the mux_nx1_rr stream mux.
//            sel_width : width of a channel index (minimum 1)
//            rr_next   : round-robin pointer increment with explicit wrap
//            rr_dist   : search distance of a channel from the pointer
// Options  : MUX_NX1_FORCE_EN (forced select, see mux_nx1_rr)
// Revision : 1.0  initial release
// ============================================================================
package mux_nx1_pkg;

    localparam int unsigned C_DEFAULT_N = 4;
    localparam int unsigned C_DEFAULT_W = 8;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit compare-and-wrap so non-power-of-two N needs no modulo.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

    // Position of channel ch in the search order ptr, ptr+1, ..., ptr-1.
    function automatic int unsigned rr_dist(input int unsigned ch, input int unsigned ptr,
                                            input int unsigned n);
        return (ch >= ptr) ? (ch - ptr) : (ch + n - ptr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_rr_if
// Purpose  : Handshake bundle for mux_nx1_rr.
//            in_data/in_valid/in_ready : N producer channels (W bits each)
//            out_data/out_valid/out_ready/out_sel : single consumer port
//            force_en/force_sel : only when MUX_NX1_FORCE_EN is defined
//            slave  modport : the mux side
//            master modport : producers/consumer side
// Revision : 1.0  initial release
// ============================================================================
interface mux_nx1_rr_if
    import mux_nx1_pkg::*;
#(
    parameter int unsigned N = C_DEFAULT_N,
    parameter int unsigned W = C_DEFAULT_W
);
    localparam int unsigned SW = sel_width(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;
`ifdef MUX_NX1_FORCE_EN
    logic           force_en;
    logic [SW-1:0]  force_sel;
`endif

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef MUX_NX1_FORCE_EN
        input  force_en, force_sel,
`endif
        output in_ready, out_data, out_valid, out_sel
    );

    modport master (
        output in_data, in_valid, out_ready,
`ifdef MUX_NX1_FORCE_EN
        output force_en, force_sel,
`endif
        input  in_ready, out_data, out_valid, out_sel
    );

endinterface
`default_nettype wire

// File: rtl/mux_nx1_rr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant selection over N valid requests, plus the
//            registered round-robin pointer.
//            valid       : per-channel request
//            enable      : a transfer takes the grant this cycle
//            grant       : granted channel index
//            grant_valid : some channel is granted
//            ptr         : current round-robin start position
//            force_en/force_sel (MUX_NX1_FORCE_EN): fixed select override
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import mux_nx1_pkg::*;
#(
    parameter int unsigned N  = C_DEFAULT_N,
    parameter int unsigned SW = sel_width(N)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [N-1:0]  valid,
    input  wire logic          enable,
`ifdef MUX_NX1_FORCE_EN
    input  wire logic          force_en,
    input  wire logic [SW-1:0] force_sel,
`endif
    output logic [SW-1:0]      grant,
    output logic               grant_valid,
    output logic [SW-1:0]      ptr
);

    logic [SW-1:0] w_rr_grant;
    logic          w_rr_hit;
    logic          w_advance;
    int unsigned   w_best_dist;

    // Smallest search distance from ptr wins among valid channels.
    always_comb begin
        w_rr_grant  = '0;
        w_rr_hit    = 1'b0;
        w_best_dist = N;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid[i] && (rr_dist(i, 32'(ptr), N) < w_best_dist)) begin
                w_best_dist = rr_dist(i, 32'(ptr), N);
                w_rr_grant  = SW'(i);
                w_rr_hit    = 1'b1;
            end
        end
    end

`ifdef MUX_NX1_FORCE_EN
    logic w_force_hit;

    // Matching against each in-range index also rejects force_sel >= N.
    always_comb begin
        w_force_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((force_sel == SW'(i)) && valid[i]) begin
                w_force_hit = 1'b1;
            end
        end
    end

    assign grant       = force_en ? force_sel   : w_rr_grant;
    assign grant_valid = force_en ? w_force_hit : w_rr_hit;
    assign w_advance   = !force_en;
`else
    assign grant       = w_rr_grant;
    assign grant_valid = w_rr_hit;
    assign w_advance   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (enable && grant_valid && w_advance) begin
            ptr <= SW'(rr_next(32'(grant), N));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_rr
// Purpose  : N-to-1 valid/ready stream mux with round-robin arbitration and
//            a one-entry registered output stage (no bubble when streaming).
//            clk, rst : clock and synchronous active-high reset
//            bus      : mux_nx1_rr_if slave (inputs, output, select index)
// Options  : MUX_NX1_FORCE_EN adds force_en/force_sel to bypass round-robin.
// Revision : 1.0  initial release
// ============================================================================
module mux_nx1_rr
    import mux_nx1_pkg::*;
#(
    parameter int unsigned N = C_DEFAULT_N,
    parameter int unsigned W = C_DEFAULT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mux_nx1_rr_if.slave   bus
);

    localparam int unsigned SW = sel_width(N);

    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic [SW-1:0] r_out_sel;

    logic          w_load;
    logic          w_take;
    logic [SW-1:0] w_grant;
    logic          w_grant_valid;
    logic [SW-1:0] w_ptr;
    logic [W-1:0]  w_sel_data;
    logic [N-1:0]  w_in_ready;

    // Output register may accept a new beat when empty or being drained.
    assign w_load = !r_out_valid || bus.out_ready;
    // Reset suppresses any handshake on the edge it is sampled.
    assign w_take = w_load && w_grant_valid && !rst;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       (bus.in_valid),
        .enable      (w_take),
`ifdef MUX_NX1_FORCE_EN
        .force_en    (bus.force_en),
        .force_sel   (bus.force_sel),
`endif
        .grant       (w_grant),
        .grant_valid (w_grant_valid),
        .ptr         (w_ptr)
    );

    always_comb begin
        w_sel_data = '0;
        w_in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_sel_data    = bus.in_data[i*W +: W];
                w_in_ready[i] = w_take;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_grant;
            end else begin
                // Data and select keep their last values when idle.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nx1_rr
// Purpose  : Self-checking bench for mux_nx1_rr (N=4 and N=3 instances).
// Options  : MUX_NX1_FORCE_EN enables the forced-select sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_nx1_rr;
    import mux_nx1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mux_nx1_rr_if #(.N(4), .W(8)) bus_a ();
    mux_nx1_rr_if #(.N(3), .W(8)) bus_b ();

    mux_nx1_rr #(.N(4), .W(8)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    mux_nx1_rr #(.N(3), .W(8)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    // Reference model state for the randomized phase.
    int          m_ptr;
    logic        m_ov;
    logic [7:0]  m_od;
    int          m_os;

    initial begin
        // Round-robin, backpressure, idle and sparse rows (data 0xA0+i).
        tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
        tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
        tbl[6]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
        tbl[7]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 8'hA0};
        tbl[8]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
        tbl[9]  = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'hA1};
        tbl[10] = '{4'h5, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
        tbl[11] = '{4'h1, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_data   = 32'hA3A2A1A0;
        bus_a.in_valid  = 4'hF;
        bus_a.out_ready = 1'b1;
        bus_b.in_data   = 24'hB2B1B0;
        bus_b.in_valid  = 3'b000;
        bus_b.out_ready = 1'b1;
`ifdef MUX_NX1_FORCE_EN
        bus_a.force_en  = 1'b0;
        bus_a.force_sel = 2'd0;
        bus_b.force_en  = 1'b0;
        bus_b.force_sel = 2'd0;
`endif

        // Reset with every channel valid.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus_a.out_data),  32'd0);
        chk("rst_out_sel",   32'(bus_a.out_sel),   32'd0);
        chk("rst_in_ready",  32'(bus_a.in_ready),  32'd0);

        @(negedge clk);
        rst_a = 1'b0;
        bus_a.in_valid = 4'h0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus_a.in_valid  = tbl[i].valid;
            bus_a.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus_a.in_ready), 32'(tbl[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus_a.out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_out_sel", i),   32'(bus_a.out_sel),   32'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d_out_data", i),  32'(bus_a.out_data),  32'(tbl[i].exp_data));
        end

        // Mid-stream reset: park ptr at 3 with a held beat, then reset.
        @(negedge clk);
        bus_a.in_valid = 4'h4; bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mrst_pre_sel", 32'(bus_a.out_sel), 32'd2);
        @(negedge clk);
        bus_a.in_valid = 4'hC; bus_a.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mrst_held_valid", 32'(bus_a.out_valid), 32'd1);
        chk("mrst_held_sel",   32'(bus_a.out_sel),   32'd2);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mrst_out_valid", 32'(bus_a.out_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b0; bus_a.out_ready = 1'b1;
        #1;
        chk("mrst_first_ir", 32'(bus_a.in_ready), 32'h4);
        @(posedge clk); #1;
        chk("mrst_first_sel",  32'(bus_a.out_sel),  32'd2);
        chk("mrst_first_data", 32'(bus_a.out_data), 32'hA2);

        // Sparse wrap on N=3: move ptr to 1, then channels 2 and 0 alternate.
        @(negedge clk);
        rst_b = 1'b0; bus_b.in_valid = 3'b001;
        @(posedge clk); #1;
        chk("n3_first_sel", 32'(bus_b.out_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_b.in_valid = 3'b101;
            @(posedge clk); #1;
            chk($sformatf("n3_wrap%0d_sel", i),  32'(bus_b.out_sel),  (i == 1) ? 32'd0 : 32'd2);
            chk($sformatf("n3_wrap%0d_data", i), 32'(bus_b.out_data), (i == 1) ? 32'hB0 : 32'hB2);
        end

`ifdef MUX_NX1_FORCE_EN
        @(negedge clk);
        rst_a = 1'b1; bus_a.in_valid = 4'hF; bus_a.out_ready = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; bus_a.force_en = 1'b1; bus_a.force_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("force%0d_sel", i), 32'(bus_a.out_sel), 32'd1);
            chk($sformatf("force%0d_ov", i),  32'(bus_a.out_valid), 32'd1);
        end
        @(negedge clk);
        bus_a.force_en = 1'b0;
        @(posedge clk); #1;
        chk("force_ptr_kept", 32'(bus_a.out_sel), 32'd0);
        @(negedge clk);
        bus_a.force_en = 1'b1; bus_a.in_valid = 4'hD;
        #1;
        chk("force_miss_ir", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("force_miss_ov", 32'(bus_a.out_valid), 32'd0);
        @(negedge clk);
        bus_a.force_en = 1'b0;
`endif

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst_a = 1'b1; bus_a.in_valid = 4'h0;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        m_ptr = 0; m_ov = 1'b0; m_od = 8'h00; m_os = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic [3:0]  v;
            logic [31:0] d;
            logic        rdy;
            logic        load;
            logic        found;
            int          g;
            logic [3:0]  exp_ir;
            if (cyc != 0) @(negedge clk);
            v   = 4'($urandom_range(0, 15));
            d   = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            bus_a.in_valid  = v;
            bus_a.in_data   = d;
            bus_a.out_ready = rdy;
            load  = !m_ov || rdy;
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!found && (((v >> c) & 4'd1) != 4'd0)) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            exp_ir = (load && found) ? 4'(1 << g) : 4'h0;
            #1;
            chk($sformatf("rnd%0d_in_ready", cyc), 32'(bus_a.in_ready), 32'(exp_ir));
            @(posedge clk); #1;
            if (load) begin
                if (found) begin
                    m_ov  = 1'b1;
                    m_od  = 8'(d >> (8 * g));
                    m_os  = g;
                    m_ptr = (g + 1) % 4;
                end else begin
                    m_ov = 1'b0;
                end
            end
            chk($sformatf("rnd%0d_out_valid", cyc), 32'(bus_a.out_valid), 32'(m_ov));
            chk($sformatf("rnd%0d_out_sel", cyc),   32'(bus_a.out_sel),   32'(m_os));
            chk($sformatf("rnd%0d_out_data", cyc),  32'(bus_a.out_data),  32'(m_od));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-to-1 multiplexer for valid/ready streams: round-robin arbitration across N input channels of W-bit data, feeding a single registered output stage. It is the sequential, handshaked successor to the fixed 4:1 combinational selector. It sits between multiple producers and one shared consumer.

## Interface
- N, default 4: number of input channels, at least 1; any value, not only powers of two.
- W, default 8: data width per channel.
- SW, local: `$clog2(N)`, minimum 1. Width of the select/index fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready. At most one bit is set per cycle.
- out_data  out  W  registered output data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_sel  out  SW  index of the channel that produced out_data.
- force_en  in  1  present only with MUX_NX1_FORCE_EN.
- force_sel  in  SW  present only with MUX_NX1_FORCE_EN.

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, in_ready=0.
- load = !out_valid | out_ready. This is a one-entry pipeline register with no bubble on back-to-back traffic.
- Grant g is the first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[g] = load & in_valid[g]. All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid and out_ready.
  - in_valid must never depend on in_ready.
- On a transfer (load and a grant exists), the next edge sets:
  - out_data ← channel g data
  - out_sel ← g
  - out_valid ← 1
  - ptr ← (g == N-1) ? 0 : g+1. Explicit wrap; no modulo on non-power-of-two N.
- load with no grant: out_valid ← 0. out_data and out_sel hold their last values.
- !load: the output register and ptr hold. out_data and out_sel stay stable while out_valid & !out_ready.
- N=1: always grant channel 0; ptr stays 0.
- Reset asserted mid-stream: any held beat is dropped, with no handshake completed on that edge.

## Timing
- Latency is 1 cycle from the input handshake to out_valid.
- Throughput is 1 beat/cycle whenever out_ready is held high.
- Fairness, with all channels valid and out_ready=1: grants 0,1,…,N-1,0,… A channel waits at most N-1 grants.
- No combinational path from in_data to out_data.

## Configuration
- MUX_NX1_FORCE_EN defined: force_en/force_sel ports exist.
  - When force_en=1, the grant is force_sel if force_sel<N and in_valid[force_sel]. Otherwise there is no grant and every in_ready is 0.
  - ptr is not updated on forced transfers.
  - force_sel ≥ N is the out-of-range select and grants nothing.
- Undefined: the ports are absent and arbitration is pure round-robin.

## Structure
- Package mux_nx1_pkg holds the shared constants and the rr_next function computing the wrapped pointer increment.
- Sub-module rr_arbiter: takes in_valid, ptr, and the enable; gives the grant index, a grant-valid flag, and the registered ptr update.
- mux_nx1_rr instantiates rr_arbiter and owns the output register and the data select.

## Test plan
- Reset: hold rst=1 with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0.
- Round-robin, N=4, W=8: all valid, data 0xA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with a beat held → out_data/out_sel unchanged, in_ready all 0. Raising out_ready resumes with the next rr channel.
- Sparse/wrap, N=3: only channels 2 and 0 valid, ptr=1 → grants 2, then 0, then 2. Pointer wraps 2→0.
- Mid-stream reset: assert rst while out_valid=1, out_ready=0 → next cycle out_valid=0 and ptr=0. The first grant after release is the lowest valid channel.
- With MUX_NX1_FORCE_EN:
  - force_en=1, force_sel=1, channels 0-3 valid → repeated grants to channel 1 and ptr unchanged.
  - force_sel=1 with channel 1 invalid → out_valid drops to 0.
